aes_input_packer: RTL and testbench

- Upstream feeder for the pipelined AES encoder/decoder.
- Accepts 32-bit plaintext/ciphertext words and 32-bit key words over valid/ready handshakes.
- Packs them into a 128-bit state_t and key_t held stable at the cipher inputs, and pulses a block strobe when a new block is complete.
- A latency-matched valid shift register tells downstream logic which cipher output cycles carry real blocks.

---
 rtl/aes_input_packer_pkg.sv | 25 ++
 rtl/aes_input_packer_valid_delay_line.sv | 34 +++
 rtl/aes_input_packer.sv | 121 ++++++++++++
 tb/tb_aes_input_packer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_input_packer_pkg.sv
// Shared types and constants for the AES input packer slice.
//   state_t / key_t  : 128-bit cipher state and key vectors
//   packerState_t    : packer handshake FSM encoding
//   AES_WORD_W       : width of one input word
//   AES_PIPE_DEPTH   : cipher latency, one clock per buffered round
`ifndef NUM_ROUNDS
`define NUM_ROUNDS 10
`endif

package aes_input_packer_pkg;

  typedef logic [127:0] state_t;
  typedef logic [127:0] key_t;

  typedef enum logic [1:0] {
    NO_KEY,
    KEY_LOAD,
    READY,
    FILL
  } packerState_t;

  localparam int AES_WORD_W     = 32;
  localparam int AES_PIPE_DEPTH = `NUM_ROUNDS + 1;

endpackage

// File: rtl/aes_input_packer_valid_delay_line.sv
// valid_delay_line: 1-bit shift register that delays a valid strobe by
// DEPTH clocks so it lines up with the output of a pipelined datapath.
//   clock : rising-edge clock
//   reset : asynchronous active-high, clears every stage
//   din   : strobe entering the line
//   dout  : din delayed by DEPTH clocks
module valid_delay_line
  import aes_input_packer_pkg::*;
#(
  parameter int DEPTH = AES_PIPE_DEPTH
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] vp;

  if (DEPTH == 1) begin : g_one
    always_ff @(posedge clock or posedge reset) begin
      if (reset) vp <= '0;
      else       vp <= din;
    end
  end else begin : g_many
    always_ff @(posedge clock or posedge reset) begin
      if (reset) vp <= '0;
      else       vp <= {vp[DEPTH-2:0], din};
    end
  end

  assign dout = vp[DEPTH-1];

endmodule

// File: rtl/aes_input_packer.sv
// aes_input_packer: collects 32-bit key and data words over valid/ready
// handshakes, packs them MS word first into 128-bit key/state vectors held
// stable at the cipher inputs, and tracks cipher latency for each block.
//   clock, reset         : rising-edge clock, asynchronous active-high reset
//   key_valid/ready/data : key word stream (4 words per key)
//   din_valid/ready/data : data word stream (4 words per block)
//   state_out            : last complete block, held until the next one
//   key_out, key_loaded  : last complete key and its presence flag
//   blk_valid            : one-cycle pulse when state_out takes a new block
//   out_valid            : blk_valid delayed PIPE_DEPTH clocks
module aes_input_packer
  import aes_input_packer_pkg::*;
#(
  parameter int WORD_W          = AES_WORD_W,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int PIPE_DEPTH      = AES_PIPE_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [WORD_W-1:0] key_data,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [WORD_W-1:0] din_data,
  output state_t            state_out,
  output key_t              key_out,
  output logic              key_loaded,
  output logic              blk_valid,
  output logic              out_valid
);

  localparam int CNT_W = $clog2(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_BLOCK - 1);

  // Highest word index holds the first (most-significant) word.
  typedef logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] words_t;

  packerState_t     state_q, state_d;
  logic [CNT_W-1:0] kcnt_q, dcnt_q;
  words_t           shadow_key_q, shadow_state_q;
  words_t           key_merged, state_merged;
  logic             key_fire, din_fire;

  // Key wins over data in READY, so din_ready depends on key_valid.
  always_comb begin
    key_ready = (state_q != FILL);
    din_ready = (state_q == FILL) || ((state_q == READY) && !key_valid);
  end

  assign key_fire = key_valid && key_ready;
  assign din_fire = din_valid && din_ready;

  // Shadow contents including the word being accepted this cycle, so the
  // completing edge can publish the whole vector at once.
  always_comb begin
    key_merged                = shadow_key_q;
    key_merged[LAST - kcnt_q] = key_data;
    state_merged                = shadow_state_q;
    state_merged[LAST - dcnt_q] = din_data;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NO_KEY:   if (key_fire) state_d = KEY_LOAD;
      KEY_LOAD: if (key_fire && (kcnt_q == LAST)) state_d = READY;
      READY: begin
        if (key_fire)      state_d = KEY_LOAD;
        else if (din_fire) state_d = FILL;
      end
      FILL:     if (din_fire && (dcnt_q == LAST)) state_d = READY;
      default:  state_d = NO_KEY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= NO_KEY;
      kcnt_q         <= '0;
      dcnt_q         <= '0;
      shadow_key_q   <= '0;
      shadow_state_q <= '0;
      key_out        <= '0;
      state_out      <= '0;
      key_loaded     <= 1'b0;
      blk_valid      <= 1'b0;
    end else begin
      state_q   <= state_d;
      blk_valid <= 1'b0;
      // Counters only advance on handshakes, so they wrap to 0 exactly on
      // the completing word and start each key/block at word 0.
      if (key_fire) begin
        shadow_key_q <= key_merged;
        kcnt_q       <= kcnt_q + CNT_W'(1);
        if ((state_q == KEY_LOAD) && (kcnt_q == LAST)) begin
          key_out    <= key_merged;
          key_loaded <= 1'b1;
        end
      end
      if (din_fire) begin
        shadow_state_q <= state_merged;
        dcnt_q         <= dcnt_q + CNT_W'(1);
        if ((state_q == FILL) && (dcnt_q == LAST)) begin
          state_out <= state_merged;
          blk_valid <= 1'b1;
        end
      end
    end
  end

  valid_delay_line #(
    .DEPTH(PIPE_DEPTH)
  ) u_valid_pipe (
    .clock (clock),
    .reset (reset),
    .din   (blk_valid),
    .dout  (out_valid)
  );

endmodule

// File: tb/tb_aes_input_packer.sv
// Directed bench for aes_input_packer: key load, single and back-to-back
// blocks, key priority in READY, reset mid-fill and gapped data input.
module tb_aes_input_packer;
  import aes_input_packer_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic [31:0] key_data = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [31:0] din_data = '0;
  state_t      state_out;
  key_t        key_out;
  logic        key_loaded;
  logic        blk_valid;
  logic        out_valid;

  aes_input_packer #(
    .WORD_W(32),
    .WORDS_PER_BLOCK(4),
    .PIPE_DEPTH(11)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_data   (key_data),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_data   (din_data),
    .state_out  (state_out),
    .key_out    (key_out),
    .key_loaded (key_loaded),
    .blk_valid  (blk_valid),
    .out_valid  (out_valid)
  );

  always #5 clock = ~clock;

  localparam logic [127:0] KEY1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BLKF  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BLKA  = 128'h0123456789abcdeffedcba9876543210;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int blk_log[$];
  int out_log[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (blk_valid) blk_log.push_back(cyc);
    if (out_valid) out_log.push_back(cyc);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic put_key(input logic [31:0] w);
    int t;
    @(negedge clock);
    key_valid = 1'b1;
    key_data  = w;
    #1;
    t = 0;
    while (!key_ready && t < 20) begin
      @(negedge clock); #1; t++;
    end
    if (t >= 20) begin
      n_checks++; n_fail++;
      $display("FAIL key_ready_timeout: key_ready=%b required 1", key_ready);
    end
    @(posedge clock);
  endtask

  task automatic put_data(input logic [31:0] w, input int gap);
    int t;
    repeat (gap) begin
      @(negedge clock);
      din_valid = 1'b0;
    end
    @(negedge clock);
    din_valid = 1'b1;
    din_data  = w;
    #1;
    t = 0;
    while (!din_ready && t < 20) begin
      @(negedge clock); #1; t++;
    end
    if (t >= 20) begin
      n_checks++; n_fail++;
      $display("FAIL din_ready_timeout: din_ready=%b required 1", din_ready);
    end
    @(posedge clock);
  endtask

  task automatic idle();
    @(negedge clock);
    key_valid = 1'b0;
    din_valid = 1'b0;
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    logic [127:0] kv;
    kv = k;
    put_key(kv[127:96]);
    put_key(kv[95:64]);
    put_key(kv[63:32]);
    put_key(kv[31:0]);
    idle();
  endtask

  task automatic test_reset();
    din_valid = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    n_checks++; if (state_out !== '0) begin n_fail++; $display("FAIL reset_state_out: got %h required 0", state_out); end
    n_checks++; if (key_out !== '0) begin n_fail++; $display("FAIL reset_key_out: got %h required 0", key_out); end
    n_checks++; if (key_loaded !== 1'b0) begin n_fail++; $display("FAIL reset_key_loaded: got %b required 0", key_loaded); end
    n_checks++; if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_blk_valid: got %b required 0", blk_valid); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_checks++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL reset_key_ready: got %b required 1", key_ready); end
    n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL reset_din_ready: got %b required 0", din_ready); end
    din_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL nokey_din_ready: got %b required 0", din_ready); end
  endtask

  task automatic test_key_load();
    put_key(32'h00010203);
    put_key(32'h04050607);
    put_key(32'h08090a0b);
    idle();
    din_valid = 1'b1;
    #1;
    n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL keyload_din_ready: got %b required 0", din_ready); end
    din_valid = 1'b0;
    n_checks++; if (key_loaded !== 1'b0) begin n_fail++; $display("FAIL keyload_early_loaded: got %b required 0", key_loaded); end
    n_checks++; if (key_out !== '0) begin n_fail++; $display("FAIL keyload_early_key_out: got %h required 0", key_out); end
    put_key(32'h0c0d0e0f);
    idle();
    n_checks++; if (key_out !== KEY1) begin n_fail++; $display("FAIL keyload_key_out: got %h required %h", key_out, KEY1); end
    n_checks++; if (key_loaded !== 1'b1) begin n_fail++; $display("FAIL keyload_loaded: got %b required 1", key_loaded); end
    n_checks++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL ready_din_ready: got %b required 1", din_ready); end
  endtask

  task automatic test_single_block();
    int d;
    blk_log.delete(); out_log.delete();
    put_data(32'h00112233, 0);
    put_data(32'h44556677, 0);
    put_data(32'h8899aabb, 0);
    put_data(32'hccddeeff, 0);
    idle();
    n_checks++; if (state_out !== BLKF) begin n_fail++; $display("FAIL single_state_out: got %h required %h", state_out, BLKF); end
    n_checks++; if (blk_valid !== 1'b1) begin n_fail++; $display("FAIL single_blk_valid_high: got %b required 1", blk_valid); end
    idle();
    n_checks++; if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL single_blk_valid_low: got %b required 0", blk_valid); end
    repeat (15) idle();
    n_checks++; if (blk_log.size() != 1) begin n_fail++; $display("FAIL single_blk_count: got %0d required 1", blk_log.size()); end
    n_checks++; if (out_log.size() != 1) begin n_fail++; $display("FAIL single_out_count: got %0d required 1", out_log.size()); end
    d = (blk_log.size() == 1 && out_log.size() == 1) ? out_log[0] - blk_log[0] : -1;
    n_checks++; if (d != 11) begin n_fail++; $display("FAIL single_latency: got %0d required 11", d); end
    n_checks++; if (state_out !== BLKF) begin n_fail++; $display("FAIL single_state_hold: got %h required %h", state_out, BLKF); end
  endtask

  task automatic test_back_to_back();
    int bs, os, lat;
    blk_log.delete(); out_log.delete();
    put_data(32'h01234567, 0);
    put_data(32'h89abcdef, 0);
    put_data(32'hfedcba98, 0);
    put_data(32'h76543210, 0);
    #1;
    n_checks++; if (state_out !== BLKA) begin n_fail++; $display("FAIL b2b_first_state_out: got %h required %h", state_out, BLKA); end
    put_data(32'h00112233, 0);
    put_data(32'h44556677, 0);
    put_data(32'h8899aabb, 0);
    put_data(32'hccddeeff, 0);
    idle();
    n_checks++; if (state_out !== BLKF) begin n_fail++; $display("FAIL b2b_second_state_out: got %h required %h", state_out, BLKF); end
    repeat (20) idle();
    n_checks++; if (blk_log.size() != 2) begin n_fail++; $display("FAIL b2b_blk_count: got %0d required 2", blk_log.size()); end
    n_checks++; if (out_log.size() != 2) begin n_fail++; $display("FAIL b2b_out_count: got %0d required 2", out_log.size()); end
    bs  = (blk_log.size() == 2) ? blk_log[1] - blk_log[0] : -1;
    os  = (out_log.size() == 2) ? out_log[1] - out_log[0] : -1;
    lat = (blk_log.size() >= 1 && out_log.size() >= 1) ? out_log[0] - blk_log[0] : -1;
    n_checks++; if (bs != 4) begin n_fail++; $display("FAIL b2b_blk_spacing: got %0d required 4", bs); end
    n_checks++; if (os != 4) begin n_fail++; $display("FAIL b2b_out_spacing: got %0d required 4", os); end
    n_checks++; if (lat != 11) begin n_fail++; $display("FAIL b2b_latency: got %0d required 11", lat); end
  endtask

  task automatic test_key_priority();
    blk_log.delete(); out_log.delete();
    @(negedge clock);
    key_valid = 1'b1;
    key_data  = 32'h2b7e1516;
    din_valid = 1'b1;
    din_data  = 32'hdeadbeef;
    #1;
    n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL prio_din_ready: got %b required 0", din_ready); end
    n_checks++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL prio_key_ready: got %b required 1", key_ready); end
    @(posedge clock);
    put_key(32'h28aed2a6);
    put_key(32'habf71588);
    idle();
    n_checks++; if (key_out !== KEY1) begin n_fail++; $display("FAIL prio_old_key_out: got %h required %h", key_out, KEY1); end
    n_checks++; if (key_loaded !== 1'b1) begin n_fail++; $display("FAIL prio_key_loaded: got %b required 1", key_loaded); end
    din_valid = 1'b1;
    put_key(32'h09cf4f3c);
    idle();
    n_checks++; if (key_out !== KEY2) begin n_fail++; $display("FAIL prio_new_key_out: got %h required %h", key_out, KEY2); end
    n_checks++; if (state_out !== BLKF) begin n_fail++; $display("FAIL prio_state_out: got %h required %h", state_out, BLKF); end
    n_checks++; if (blk_log.size() != 0) begin n_fail++; $display("FAIL prio_blk_count: got %0d required 0", blk_log.size()); end
  endtask

  task automatic test_reset_midfill();
    put_data(32'h01234567, 0);
    put_data(32'h89abcdef, 0);
    put_data(32'hfedcba98, 0);
    put_data(32'h76543210, 0);
    put_data(32'h00112233, 0);
    put_data(32'h44556677, 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    blk_log.delete(); out_log.delete();
    n_checks++; if (state_out !== '0) begin n_fail++; $display("FAIL midrst_state_out: got %h required 0", state_out); end
    n_checks++; if (key_out !== '0) begin n_fail++; $display("FAIL midrst_key_out: got %h required 0", key_out); end
    n_checks++; if (key_loaded !== 1'b0) begin n_fail++; $display("FAIL midrst_key_loaded: got %b required 0", key_loaded); end
    n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_din_ready: got %b required 0", din_ready); end
    n_checks++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_key_ready: got %b required 1", key_ready); end
    @(negedge clock);
    reset = 1'b0;
    din_valid = 1'b0;
    repeat (20) idle();
    n_checks++; if (out_log.size() != 0) begin n_fail++; $display("FAIL midrst_out_pulses: got %0d required 0", out_log.size()); end
    n_checks++; if (state_out !== '0) begin n_fail++; $display("FAIL midrst_state_hold: got %h required 0", state_out); end
    din_valid = 1'b1;
    #1;
    n_checks++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_nokey_din_ready: got %b required 0", din_ready); end
    din_valid = 1'b0;
  endtask

  task automatic test_gaps();
    logic [127:0] b;
    load_key(KEY1);
    blk_log.delete(); out_log.delete();
    b = BLKF;
    put_data(b[127:96], int'($urandom_range(0, 5)));
    put_data(b[95:64],  int'($urandom_range(1, 5)));
    put_data(b[63:32],  int'($urandom_range(0, 5)));
    idle();
    n_checks++; if (blk_log.size() != 0) begin n_fail++; $display("FAIL gaps_early_blk: got %0d required 0", blk_log.size()); end
    put_data(b[31:0],   int'($urandom_range(0, 5)));
    idle();
    n_checks++; if (state_out !== BLKF) begin n_fail++; $display("FAIL gaps_state_out: got %h required %h", state_out, BLKF); end
    n_checks++; if (blk_valid !== 1'b1) begin n_fail++; $display("FAIL gaps_blk_valid: got %b required 1", blk_valid); end
    repeat (15) idle();
    n_checks++; if (blk_log.size() != 1) begin n_fail++; $display("FAIL gaps_blk_count: got %0d required 1", blk_log.size()); end
    n_checks++; if (out_log.size() != 1) begin n_fail++; $display("FAIL gaps_out_count: got %0d required 1", out_log.size()); end
  endtask

  initial begin
    test_reset();
    test_key_load();
    test_single_block();
    test_back_to_back();
    test_key_priority();
    test_reset_midfill();
    test_gaps();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
